ysyx_22041752_sram_arb: RTL and testbench

Two-requester arbiter that shares one synchronous single-port SRAM between the instruction-fetch path (IF) and the load/store path (LS) of the 5-stage core. It sits between IFU/EXU/MEU and the memory port, and replaces the separate inst/data SRAM ports when the core is built against a unified memory. Requesters hold requests until granted. LS has priority, with a bounded-starvation guard for IF. Read data returns one cycle after grant, tagged to its owner, and a pending IF response can be dropped by pipeline flush.

---
 rtl/ysyx_22041752_sram_arb.sv | 61 ++++++
 tb/tb_ysyx_22041752_sram_arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_sram_arb.sv
// ysyx_22041752_sram_arb: shares one single-port SRAM between IF and LS, LS first with an IF starvation guard.
module ysyx_22041752_sram_arb #(
  parameter int ADDR_WD    = 32,
  parameter int DATA_WD    = 64,
  parameter int WEN_WD     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_WD-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [DATA_WD-1:0] if_rdata,
  input  logic               ls_req,
  input  logic [WEN_WD-1:0]  ls_wen,
  input  logic [ADDR_WD-1:0] ls_addr,
  input  logic [DATA_WD-1:0] ls_wdata,
  output logic               ls_gnt,
  output logic               ls_rvalid,
  output logic [DATA_WD-1:0] ls_rdata,
  input  logic               flush,
  output logic               mem_en,
  output logic [WEN_WD-1:0]  mem_wen,
  output logic [ADDR_WD-1:0] mem_addr,
  output logic [DATA_WD-1:0] mem_wdata,
  input  logic [DATA_WD-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, IF_RESP, LS_RESP} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t     state;
  logic [3:0] starve_cnt;
  logic       drop;
  logic       force_if;
  always_comb begin
    force_if  = if_req && starve_cnt == SMAX;
    ls_gnt    = ls_req && !force_if;
    if_gnt    = if_req && !ls_gnt;
    mem_en    = if_gnt || ls_gnt;
    mem_wen   = ls_gnt ? ls_wen : '0;
    mem_addr  = ls_gnt ? ls_addr : if_gnt ? if_addr : '0;
    mem_wdata = ls_gnt ? ls_wdata : '0;
  end
  // Next state reflects only this cycle's grant, so every state accepts a new grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
    end else begin
      state      <= if_gnt ? IF_RESP : (ls_gnt && ls_wen == '0) ? LS_RESP : IDLE;
      drop       <= if_gnt && flush;
      starve_cnt <= (!if_req || if_gnt) ? '0 :
                    (ls_gnt && starve_cnt != SMAX) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
  assign if_rvalid = state == IF_RESP && !drop && !flush;
  assign if_rdata  = state == IF_RESP ? mem_rdata : '0;
  assign ls_rvalid = state == LS_RESP;
  assign ls_rdata  = state == LS_RESP ? mem_rdata : '0;
endmodule

// File: tb/tb_ysyx_22041752_sram_arb.sv
// tb_ysyx_22041752_sram_arb: directed stimulus with a response scoreboard and an SRAM model.
module tb_ysyx_22041752_sram_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0;
  logic [7:0]  ls_wen = '0;
  logic [63:0] ls_wdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en;
  logic [63:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] ram [0:63];
  int          cyc = 0;
  int          vecs = 0;
  int          errs = 0;
  typedef struct {logic [63:0] d; int due;} exp_t;
  exp_t exp_if[$];
  exp_t exp_ls[$];

  ysyx_22041752_sram_arb dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .flush(flush),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM model; preloaded while reset is held low.
  always @(posedge clk) begin
    if (!reset) begin
      ram[0] <= 64'h11223344_55667788;
      ram[1] <= 64'h01234567_89ABCDEF;
      ram[2] <= 64'hFEDCBA98_76543210;
      ram[3] <= 64'h33333333_33333333;
      ram[4] <= 64'h04040404_04040404;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_wen == '0) mem_rdata <= ram[mem_addr[8:3]];
      else for (int i = 0; i < 8; i++)
        if (mem_wen[i]) ram[mem_addr[8:3]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (if_rvalid) begin
      if (exp_if.size() == 0) chk("if_rvalid_unexpected", 64'(if_rvalid), 64'd0);
      else begin
        e = exp_if.pop_front();
        chk("if_rdata", if_rdata, e.d);
        chk("if_latency", 64'(cyc), 64'(e.due));
      end
    end
    if (ls_rvalid) begin
      if (exp_ls.size() == 0) chk("ls_rvalid_unexpected", 64'(ls_rvalid), 64'd0);
      else begin
        e = exp_ls.pop_front();
        chk("ls_rdata", ls_rdata, e.d);
        chk("ls_latency", 64'(cyc), 64'(e.due));
      end
    end
    while (exp_if.size() > 0 && exp_if[0].due < cyc) begin
      e = exp_if.pop_front();
      chk("if_rvalid_missing", 64'd0, e.d);
    end
    while (exp_ls.size() > 0 && exp_ls[0].due < cyc) begin
      e = exp_ls.pop_front();
      chk("ls_rvalid_missing", 64'd0, e.d);
    end
  end

  // One cycle of stimulus: drive, check grant/mem port at negedge, queue expected response if p.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic [7:0] lw,
                      input logic [31:0] la, input logic [63:0] ld, input logic fl,
                      input logic eg_if, input logic eg_ls, input logic p, input logic [63:0] dat);
    exp_t e;
    if_req = ir; if_addr = ia; ls_req = lr; ls_wen = lw; ls_addr = la; ls_wdata = ld; flush = fl;
    @(negedge clk);
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("ls_gnt", 64'(ls_gnt), 64'(eg_ls));
    chk("mem_en", 64'(mem_en), 64'(eg_if | eg_ls));
    chk("mem_addr", 64'(mem_addr), eg_ls ? 64'(la) : eg_if ? 64'(ia) : 64'd0);
    chk("mem_wen", 64'(mem_wen), eg_ls ? 64'(lw) : 64'd0);
    chk("mem_wdata", mem_wdata, eg_ls ? ld : 64'd0);
    e.d = dat; e.due = cyc + 1;
    if (p && eg_if) exp_if.push_back(e);
    if (p && eg_ls && lw == 8'h00) exp_ls.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    if_req = 1'b1; ls_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("rst_ls_rvalid", 64'(ls_rvalid), 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_ls_rdata", ls_rdata, 64'd0);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0; reset = 1'b1;
    idle(2);
    // single IF read
    step(1, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 0, 1, 64'h11223344_55667788);
    idle(1);
    // LS read then IF read back to back
    step(0, 0, 1, 8'h00, 32'h8000_0010, 0, 0, 0, 1, 1, 64'hFEDCBA98_76543210);
    step(1, 32'h8000_0008, 0, 0, 0, 0, 0, 1, 0, 1, 64'h01234567_89ABCDEF);
    idle(1);
    // starvation: continuous LS writes vs continuous IF requests
    for (int k = 0; k < 11; k++)
      step(1, 32'h8000_0000, 1, 8'hFF, 32'h8000_0018, 64'hDEADBEEF_CAFEF00D, 0,
           (k % 5) == 4, (k % 5) != 4, 1, 64'h11223344_55667788);
    idle(1);
    step(0, 0, 1, 8'h00, 32'h8000_0018, 0, 0, 0, 1, 1, 64'hDEADBEEF_CAFEF00D);
    // partial byte write then readback
    step(0, 0, 1, 8'h0F, 32'h8000_0020, 64'hFFFFFFFF_FFFFFFFF, 0, 0, 1, 0, 0);
    step(0, 0, 1, 8'h00, 32'h8000_0020, 0, 0, 0, 1, 1, 64'h04040404_FFFFFFFF);
    idle(1);
    // flush in the grant cycle, LS read in the next cycle still returns
    step(1, 32'h8000_0008, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 8'h00, 32'h8000_0000, 0, 0, 0, 1, 1, 64'h11223344_55667788);
    idle(1);
    // flush in the response cycle
    step(1, 32'h8000_0010, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // asynchronous reset with an LS read outstanding
    step(0, 0, 1, 8'h00, 32'h8000_0008, 0, 0, 0, 1, 0, 0);
    #1 chk("ls_rvalid_pre_rst", 64'(ls_rvalid), 64'd1);
    reset = 1'b0;
    #1 chk("ls_rvalid_async_rst", 64'(ls_rvalid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(3);
    chk("if_queue_empty", 64'(exp_if.size()), 64'd0);
    chk("ls_queue_empty", 64'(exp_ls.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
